// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus arbiter: sequencer states, strobe levels, defaults.
// No logic; imported by the arbiter and the sequencer.
package rtc_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_GAP1,
      ST_DATA,
      ST_GAP2,
      ST_DONE
   } state_t;

   // RTC strobes are active-low
   localparam logic STB_IDLE = 1'b1;
   localparam logic STB_ACT  = 1'b0;

   localparam int DEF_T_PH = 4;
   localparam int DEF_N_CH = 6;

endpackage

// File: rtl/rtc_rr_arbiter.sv
// Combinational requester selection: fixed priority (lowest index) or round-robin after ptr.
// Zero latency; no state, the caller decides when a grant is taken.
import rtc_bus_pkg::*;

module rtc_rr_arbiter #(
   parameter int N_CH = DEF_N_CH
) (
   input  logic [N_CH-1:0]         req,
   input  logic [$clog2(N_CH)-1:0] ptr,
   input  logic                    mode,
   output logic [N_CH-1:0]         gnt,
   output logic [$clog2(N_CH)-1:0] idx
);

   localparam int IW = $clog2(N_CH);

   logic [IW:0] cand;
   logic        found;

   // One spare bit in cand lets ptr+1+i exceed N_CH before a single wrap subtraction
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (mode) begin
            cand = {1'b0, ptr} + (IW+1)'(i + 1);
         end else begin
            cand = (IW+1)'(i);
         end
         if (cand >= (IW+1)'(N_CH)) begin
            cand = cand - (IW+1)'(N_CH);
         end
         if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            idx   = cand[IW-1:0];
         end
      end
      if (found) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates N_CH requesters onto a multiplexed RTC bus; ADDR/GAP1/DATA/GAP2 each T_PH cycles.
// done at 4*T_PH+1 cycles after the request is seen; requesters hold req until done.
import rtc_bus_pkg::*;

module rtc_bus_arbiter #(
   parameter int N_CH   = DEF_N_CH,
   parameter int T_PH   = DEF_T_PH,
   parameter int ARB_RR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   req,
   input  logic [N_CH-1:0]   we,
   input  logic [N_CH-1:0]   lock,
   input  logic [8*N_CH-1:0] addr,
   input  logic [8*N_CH-1:0] wdata,
   input  logic [7:0]        ADin,
   output logic [N_CH-1:0]   gnt,
   output logic [N_CH-1:0]   done,
   output logic [7:0]        rdata,
   output logic              busy,
   output logic [7:0]        ADout,
   output logic              ad,
   output logic              cs,
   output logic              rd,
   output logic              wr,
   output logic              oe
);

   localparam int IW = $clog2(N_CH);

   state_t          state, nxt;
   logic [3:0]      cnt;
   logic            last;
   logic            load;
   logic            relock;
   logic [IW-1:0]   win;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   sel;
   logic [IW-1:0]   arb_idx;
   logic [N_CH-1:0] arb_gnt;
   logic            we_l;
   logic [7:0]      addr_l;
   logic [7:0]      wdata_l;

   rtc_rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req  (req),
      .ptr  (ptr),
      .mode (ARB_RR != 0),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   assign last = (cnt == 4'(T_PH - 1));
   assign sel  = load ? arb_idx : win;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         win     <= '0;
         ptr     <= IW'(N_CH - 1);
         we_l    <= 1'b0;
         addr_l  <= '0;
         wdata_l <= '0;
         rdata   <= '0;
      end else begin
         state <= nxt;
         if ((state inside {ST_ADDR, ST_GAP1, ST_DATA, ST_GAP2}) && !last) begin
            cnt <= cnt + 4'd1;
         end else begin
            cnt <= '0;
         end
         if (load || relock) begin
            win     <= sel;
            we_l    <= we[sel];
            addr_l  <= addr[{sel, 3'b000} +: 8];
            wdata_l <= wdata[{sel, 3'b000} +: 8];
         end
         if (load) begin
            ptr <= arb_idx;
         end
         if (state == ST_DATA && last && !we_l) begin
            rdata <= ADin;
         end
      end
   end

   always_comb begin
      nxt    = state;
      load   = 1'b0;
      relock = 1'b0;
      cs     = STB_IDLE;
      ad     = STB_IDLE;
      rd     = STB_IDLE;
      wr     = STB_IDLE;
      oe     = 1'b0;
      ADout  = '0;
      gnt    = '0;
      done   = '0;
      busy   = (state != ST_IDLE);
      if (state != ST_IDLE) begin
         gnt[win] = 1'b1;
      end
      case (state)
         ST_IDLE: begin
            if (|arb_gnt) begin
               load = 1'b1;
               nxt  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            cs    = STB_ACT;
            ad    = STB_ACT;
            wr    = STB_ACT;
            oe    = 1'b1;
            ADout = addr_l;
            if (last) nxt = ST_GAP1;
         end
         ST_GAP1: begin
            cs    = STB_ACT;
            oe    = 1'b1;
            ADout = addr_l;
            if (last) nxt = ST_DATA;
         end
         ST_DATA: begin
            cs = STB_ACT;
            if (we_l) begin
               wr    = STB_ACT;
               oe    = 1'b1;
               ADout = wdata_l;
            end else begin
               rd = STB_ACT;
            end
            if (last) nxt = ST_GAP2;
         end
         ST_GAP2: begin
            if (last) nxt = ST_DONE;
         end
         ST_DONE: begin
            done[win] = 1'b1;
            // A locked requester keeps the bus without going back through arbitration
            if (lock[win] && req[win]) begin
               relock = 1'b1;
               nxt    = ST_ADDR;
            end else begin
               nxt = ST_IDLE;
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

endmodule

// File: doc/rtc_bus_arbiter.md
RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 Parameter N_CH, default 6, number of requester channels, 2..8.
REQ-002 Parameter T_PH, default 4, clock cycles per bus phase, 1..15.
REQ-003 Parameter ARB_RR, default 0: 0 = fixed priority (channel 0 highest); 1 = round-robin.
REQ-004 clk  in  1  single system clock, all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req  in  N_CH  per-channel transaction request, level, held until done.
REQ-007 we  in  N_CH  per-channel direction: 1 = write, 0 = read.
REQ-008 lock  in  N_CH  per-channel lock: retains the bus for the next transaction.
REQ-009 addr  in  8*N_CH  per-channel RTC register address; channel k uses bits [8k+7:8k].
REQ-010 wdata  in  8*N_CH  per-channel write data, same packing.
REQ-011 ADin  in  8  RTC data bus input.
REQ-012 gnt  out  N_CH  one-hot grant, high for the whole transaction.
REQ-013 done  out  N_CH  one-cycle completion pulse to the granted channel.
REQ-014 rdata  out  8  last read byte.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 ADout  out  8  RTC multiplexed address/data output.
REQ-017 ad, cs, rd, wr  out  1 each  RTC strobes, active-low, idle high.
REQ-018 oe  out  1  AD bus output enable: 1 = drive ADout.

Function
REQ-019 States: IDLE, ADDR, GAP1, DATA, GAP2, DONE. ADDR, GAP1, DATA and GAP2 each last exactly T_PH cycles, timed by a phase counter.
REQ-020 IDLE: strobes high, oe=0, ADout=0, gnt=0. When any req bit is high, latch the winner's index, we, addr and wdata, and enter ADDR on the next cycle.
REQ-021 ADDR: cs=0, ad=0, wr=0, rd=1, oe=1, ADout=latched addr.
REQ-022 GAP1: cs=0, ad=1, wr=1, rd=1, oe=1, ADout=latched addr.
REQ-023 DATA, write: cs=0, ad=1, wr=0, rd=1, oe=1, ADout=latched wdata.
REQ-024 DATA, read: cs=0, ad=1, rd=0, wr=1, oe=0. Sample ADin into rdata on the last DATA cycle.
REQ-025 GAP2: all strobes high, oe=0.
REQ-026 DONE: one cycle; done[winner]=1; then return to IDLE, or go directly to ADDR under REQ-030.
REQ-027 Latency: req seen in IDLE at cycle 0 gives gnt from cycle 1 and done at cycle 4*T_PH+1.
REQ-028 Fixed priority: grant the lowest-index requesting channel.
REQ-029 Round-robin: search starts at (last winner + 1) mod N_CH, wrapping N_CH-1 to 0. The pointer updates only on grant.
REQ-030 If lock[winner]=1 and req[winner]=1 during DONE, skip arbitration and re-grant the same channel, entering ADDR next cycle with newly latched addr, wdata and we.
REQ-031 Inputs are latched at grant. Changes to req, addr, wdata or we during a transaction are ignored; dropping req mid-transaction does not abort it.
REQ-032 A requester deasserts req in the cycle after done. req still high in IDLE is a new request.
REQ-033 rdata holds its value until the next read completes. Writes do not change rdata.

Reset
REQ-034 Asserting rst at any time forces IDLE, strobes=1, oe=0, ADout=0, gnt=0, done=0, rdata=0, busy=0, round-robin pointer to N_CH-1 (first search starts at 0), and phase counter to 0. Any in-flight transaction is discarded with no done pulse.

Structure
REQ-035 Package rtc_bus_pkg SHALL hold the state enumeration, strobe idle/active constants, and default T_PH and N_CH.
REQ-036 Arbitration SHALL be a sub-module rtc_rr_arbiter (req vector, pointer, mode in; one-hot grant and index out, combinational). Sequencing stays in rtc_bus_arbiter.

Verification
REQ-037 Write: T_PH=4, ch2 req, we=1, addr=0x21, wdata=0x45 -> ADout=0x21 with ad=wr=cs=0 for cycles 1-4; wr=0, ADout=0x45 for cycles 9-12; done[2] at cycle 17.
REQ-038 Read: ch3 addr=0x42, ADin=0x13 during DATA -> rd=0 and oe=0 for cycles 9-12, rdata=0x13, done[3] at cycle 17.
REQ-039 Fixed priority: req=6'b101010 with ARB_RR=0 -> grants in order ch1, ch3, ch5, each held for a full transaction.
REQ-040 Round-robin: req=6'b100001 continuously with ARB_RR=1 -> grants alternate ch0, ch5, ch0, ch5; no starvation.
REQ-041 Lock: ch4 lock=1 with three back-to-back writes while ch0 also requests -> ch4 granted three times with no IDLE cycle, then ch0.
REQ-042 Reset: rst low during DATA of a write -> next cycle all strobes high, oe=0, gnt=0, no done; after release, a pending req restarts from ADDR.
